age_ordered_issue_queue: RTL and testbench

- Parametrised, age-ordered, collapsing issue queue. Successor to the fixed per-FU issue queues in the issue stage.
- Accepts up to WRITE_NUM renamed ops per cycle and captures operand data from WAKE_NUM broadcast ports.
- Each cycle it issues up to ISSUE_NUM operand-ready ops, oldest first, through registered outputs into the execute register.
- One instance per FU class (ALU, MEM, BRANCH, MULT). Depth and port counts are set per instance.

---
 rtl/age_ordered_issue_queue_if.sv | 47 ++++
 rtl/age_ordered_issue_queue.sv | 206 ++++++++++++++++++++
 tb/tb_age_ordered_issue_queue.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/age_ordered_issue_queue_if.sv
// Bundle of dispatch, wake, issue and status signals for one age-ordered issue queue.
// The dispatch side (master) drives writes and wakes; the queue (slave) returns status and issued ops.
interface age_ordered_issue_queue_if #(
    parameter int DEPTH     = 8,
    parameter int WRITE_NUM = 2,
    parameter int ISSUE_NUM = 2,
    parameter int WAKE_NUM  = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                          flush;
    logic [WRITE_NUM-1:0]          wr_valid;
    logic [WRITE_NUM-1:0]          wr_src1_rdy;
    logic [WRITE_NUM-1:0]          wr_src2_rdy;
    logic [WRITE_NUM*TAG_W-1:0]    wr_src1_tag;
    logic [WRITE_NUM*TAG_W-1:0]    wr_src2_tag;
    logic [WRITE_NUM*DATA_W-1:0]   wr_src1_data;
    logic [WRITE_NUM*DATA_W-1:0]   wr_src2_data;
    logic [WRITE_NUM*PAYLOAD_W-1:0] wr_payload;
    logic [WAKE_NUM-1:0]           wake_valid;
    logic [WAKE_NUM*TAG_W-1:0]     wake_tag;
    logic [WAKE_NUM*DATA_W-1:0]    wake_data;
    logic                          issue_stall;
    logic                          full;
    logic [CNT_W-1:0]              count;
    logic [ISSUE_NUM-1:0]          iss_valid;
    logic [ISSUE_NUM*DATA_W-1:0]   iss_src1_data;
    logic [ISSUE_NUM*DATA_W-1:0]   iss_src2_data;
    logic [ISSUE_NUM*PAYLOAD_W-1:0] iss_payload;

    modport master (
        output flush, wr_valid, wr_src1_rdy, wr_src2_rdy, wr_src1_tag, wr_src2_tag,
               wr_src1_data, wr_src2_data, wr_payload, wake_valid, wake_tag, wake_data,
               issue_stall,
        input  full, count, iss_valid, iss_src1_data, iss_src2_data, iss_payload
    );

    modport slave (
        input  flush, wr_valid, wr_src1_rdy, wr_src2_rdy, wr_src1_tag, wr_src2_tag,
               wr_src1_data, wr_src2_data, wr_payload, wake_valid, wake_tag, wake_data,
               issue_stall,
        output full, count, iss_valid, iss_src1_data, iss_src2_data, iss_payload
    );
endinterface

// File: rtl/age_ordered_issue_queue.sv
// Collapsing issue queue: entry 0 is oldest, ready ops issue oldest-first through registered ports,
// survivors shift down each cycle and new ops append at the tail.
module age_ordered_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int WRITE_NUM = 2,
    parameter int ISSUE_NUM = 2,
    parameter int WAKE_NUM  = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
) (
    input logic                    clk,
    input logic                    resetn,
    age_ordered_issue_queue_if.slave q_if
);
    // Handshake: writes are taken all-or-nothing on any edge where full==0 and flush==0;
    // an issued op is presented while iss_valid=1 and held unchanged while issue_stall=1.
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } op_t;

    typedef struct packed {
        logic                 valid;
        op_t                  src1;
        op_t                  src2;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] sel;
    int               sel_rank  [DEPTH];
    int               surv_rank [DEPTH];
    int               wr_rank   [WRITE_NUM];

    logic [CNT_W-1:0] count;
    logic             full;
    logic             accept;

    logic [ISSUE_NUM-1:0] iss_v_d;
    logic [ISSUE_NUM-1:0] iss_v_q;
    logic [DATA_W-1:0]    iss_s1_d [ISSUE_NUM];
    logic [DATA_W-1:0]    iss_s2_d [ISSUE_NUM];
    logic [PAYLOAD_W-1:0] iss_pl_d [ISSUE_NUM];
    logic [DATA_W-1:0]    iss_s1_q [ISSUE_NUM];
    logic [DATA_W-1:0]    iss_s2_q [ISSUE_NUM];
    logic [PAYLOAD_W-1:0] iss_pl_q [ISSUE_NUM];

    // Lowest matching wake port wins; tag 0 means "no producer" and never matches.
    function automatic op_t wake_op(
        input op_t                        op,
        input logic [WAKE_NUM-1:0]        wv,
        input logic [WAKE_NUM*TAG_W-1:0]  wt,
        input logic [WAKE_NUM*DATA_W-1:0] wd
    );
        op_t r;
        r = op;
        if (!op.rdy && op.tag != '0) begin
            for (int w = WAKE_NUM - 1; w >= 0; w--) begin
                if (wv[w] && wt[w*TAG_W +: TAG_W] == op.tag) begin
                    r.rdy  = 1'b1;
                    r.data = wd[w*DATA_W +: DATA_W];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(ent_q[i].valid);
        end
    end

    assign full   = (int'(count) > DEPTH - WRITE_NUM);
    assign accept = !full && !q_if.flush;

    // Ranks give each selected entry its issue port, each survivor its compacted slot,
    // and each valid write port its tail slot.
    always_comb begin
        int n_sel;
        int n_keep;
        int n_wr;
        n_sel  = 0;
        n_keep = 0;
        n_wr   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i]     = ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
            sel[i]       = 1'b0;
            sel_rank[i]  = n_sel;
            surv_rank[i] = n_keep;
            if (ready[i] && !q_if.issue_stall && n_sel < ISSUE_NUM) begin
                sel[i] = 1'b1;
                n_sel  = n_sel + 1;
            end else if (ent_q[i].valid) begin
                n_keep = n_keep + 1;
            end
        end
        for (int p = 0; p < WRITE_NUM; p++) begin
            wr_rank[p] = n_keep + n_wr;
            if (q_if.wr_valid[p]) begin
                n_wr = n_wr + 1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_d[j] = '0;
        end
        if (!q_if.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j <= i; j++) begin
                    if (ent_q[i].valid && !sel[i] && surv_rank[i] == j) begin
                        ent_d[j]      = ent_q[i];
                        ent_d[j].src1 = wake_op(ent_q[i].src1, q_if.wake_valid, q_if.wake_tag, q_if.wake_data);
                        ent_d[j].src2 = wake_op(ent_q[i].src2, q_if.wake_valid, q_if.wake_tag, q_if.wake_data);
                    end
                end
            end
            for (int p = 0; p < WRITE_NUM; p++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (accept && q_if.wr_valid[p] && wr_rank[p] == j) begin
                        ent_d[j].valid   = 1'b1;
                        ent_d[j].payload = q_if.wr_payload[p*PAYLOAD_W +: PAYLOAD_W];
                        ent_d[j].src1    = wake_op(op_t'({q_if.wr_src1_rdy[p],
                                                          q_if.wr_src1_tag[p*TAG_W +: TAG_W],
                                                          q_if.wr_src1_data[p*DATA_W +: DATA_W]}),
                                                   q_if.wake_valid, q_if.wake_tag, q_if.wake_data);
                        ent_d[j].src2    = wake_op(op_t'({q_if.wr_src2_rdy[p],
                                                          q_if.wr_src2_tag[p*TAG_W +: TAG_W],
                                                          q_if.wr_src2_data[p*DATA_W +: DATA_W]}),
                                                   q_if.wake_valid, q_if.wake_tag, q_if.wake_data);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_NUM; k++) begin
            iss_v_d[k]  = 1'b0;
            iss_s1_d[k] = '0;
            iss_s2_d[k] = '0;
            iss_pl_d[k] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (sel[i] && sel_rank[i] == k) begin
                    iss_v_d[k]  = 1'b1;
                    iss_s1_d[k] = ent_q[i].src1.data;
                    iss_s2_d[k] = ent_q[i].src2.data;
                    iss_pl_d[k] = ent_q[i].payload;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Flush drops iss_valid even under stall; the data lanes are don't-care once invalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iss_v_q <= '0;
            for (int k = 0; k < ISSUE_NUM; k++) begin
                iss_s1_q[k] <= '0;
                iss_s2_q[k] <= '0;
                iss_pl_q[k] <= '0;
            end
        end else if (q_if.flush) begin
            iss_v_q <= '0;
        end else if (!q_if.issue_stall) begin
            iss_v_q <= iss_v_d;
            for (int k = 0; k < ISSUE_NUM; k++) begin
                iss_s1_q[k] <= iss_s1_d[k];
                iss_s2_q[k] <= iss_s2_d[k];
                iss_pl_q[k] <= iss_pl_d[k];
            end
        end
    end

    assign q_if.full      = full;
    assign q_if.count     = count;
    assign q_if.iss_valid = iss_v_q;

    for (genvar k = 0; k < ISSUE_NUM; k++) begin : g_iss
        assign q_if.iss_src1_data[k*DATA_W +: DATA_W]    = iss_s1_q[k];
        assign q_if.iss_src2_data[k*DATA_W +: DATA_W]    = iss_s2_q[k];
        assign q_if.iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = iss_pl_q[k];
    end
endmodule

// File: tb/tb_age_ordered_issue_queue.sv
// Bench for the age-ordered issue queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_age_ordered_issue_queue;
    localparam int DEPTH     = 8;
    localparam int WRITE_NUM = 2;
    localparam int ISSUE_NUM = 2;
    localparam int WAKE_NUM  = 4;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    age_ordered_issue_queue_if #(
        .DEPTH(DEPTH), .WRITE_NUM(WRITE_NUM), .ISSUE_NUM(ISSUE_NUM), .WAKE_NUM(WAKE_NUM),
        .TAG_W(TAG_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)
    ) bus ();

    age_ordered_issue_queue #(
        .DEPTH(DEPTH), .WRITE_NUM(WRITE_NUM), .ISSUE_NUM(ISSUE_NUM), .WAKE_NUM(WAKE_NUM),
        .TAG_W(TAG_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .q_if   (bus)
    );

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic                 r1, r2;
        logic [TAG_W-1:0]     t1, t2;
        logic [DATA_W-1:0]    d1, d2;
        logic [PAYLOAD_W-1:0] pl;
    } mop_t;

    mop_t                 mq[$];
    logic [PAYLOAD_W-1:0] exp_q[$];
    logic [ISSUE_NUM-1:0] exp_iv;
    logic [DATA_W-1:0]    exp_s1 [ISSUE_NUM];
    logic [DATA_W-1:0]    exp_s2 [ISSUE_NUM];
    logic [PAYLOAD_W-1:0] exp_pl [ISSUE_NUM];
    bit                   new_issue;
    int                   n_checks = 0;
    int                   n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        exp_iv    = '0;
        new_issue = 1'b0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            exp_s1[k] = '0;
            exp_s2[k] = '0;
            exp_pl[k] = '0;
        end
    endtask

    function automatic mop_t wake_entry(input mop_t m);
        for (int w = 0; w < WAKE_NUM; w++) begin
            if (bus.wake_valid[w]) begin
                if (!m.r1 && m.t1 != 0 && m.t1 == bus.wake_tag[w*TAG_W +: TAG_W]) begin
                    m.r1 = 1'b1;
                    m.d1 = bus.wake_data[w*DATA_W +: DATA_W];
                end
                if (!m.r2 && m.t2 != 0 && m.t2 == bus.wake_tag[w*TAG_W +: TAG_W]) begin
                    m.r2 = 1'b1;
                    m.d2 = bus.wake_data[w*DATA_W +: DATA_W];
                end
            end
        end
        return m;
    endfunction

    // One clock of queue behaviour, computed from the current inputs and model contents.
    task automatic model_step();
        mop_t nq[$];
        mop_t m;
        int   picked;
        bit   accept;
        accept    = (mq.size() <= DEPTH - WRITE_NUM);
        new_issue = 1'b0;
        if (bus.flush) begin
            mq.delete();
            exp_iv = '0;
        end else begin
            picked = 0;
            if (!bus.issue_stall) begin
                exp_iv    = '0;
                new_issue = 1'b1;
            end
            foreach (mq[i]) begin
                m = mq[i];
                if (!bus.issue_stall && m.r1 && m.r2 && picked < ISSUE_NUM) begin
                    exp_iv[picked] = 1'b1;
                    exp_s1[picked] = m.d1;
                    exp_s2[picked] = m.d2;
                    exp_pl[picked] = m.pl;
                    exp_q.push_back(m.pl);
                    picked++;
                end else begin
                    nq.push_back(wake_entry(m));
                end
            end
            if (accept) begin
                for (int p = 0; p < WRITE_NUM; p++) begin
                    if (bus.wr_valid[p]) begin
                        m.r1 = bus.wr_src1_rdy[p];
                        m.r2 = bus.wr_src2_rdy[p];
                        m.t1 = bus.wr_src1_tag[p*TAG_W +: TAG_W];
                        m.t2 = bus.wr_src2_tag[p*TAG_W +: TAG_W];
                        m.d1 = bus.wr_src1_data[p*DATA_W +: DATA_W];
                        m.d2 = bus.wr_src2_data[p*DATA_W +: DATA_W];
                        m.pl = bus.wr_payload[p*PAYLOAD_W +: PAYLOAD_W];
                        nq.push_back(wake_entry(m));
                    end
                end
            end
            mq = nq;
        end
    endtask

    task automatic check_out(input string ctx);
        logic [PAYLOAD_W-1:0] pl;
        chk({ctx, " iss_valid"}, 128'(bus.iss_valid), 128'(exp_iv));
        for (int k = 0; k < ISSUE_NUM; k++) begin
            if (exp_iv[k]) begin
                chk({ctx, " iss_src1"}, 128'(bus.iss_src1_data[k*DATA_W +: DATA_W]), 128'(exp_s1[k]));
                chk({ctx, " iss_src2"}, 128'(bus.iss_src2_data[k*DATA_W +: DATA_W]), 128'(exp_s2[k]));
                chk({ctx, " iss_payload"}, 128'(bus.iss_payload[k*PAYLOAD_W +: PAYLOAD_W]), 128'(exp_pl[k]));
            end
            if (new_issue && bus.iss_valid[k]) begin
                chk({ctx, " stream_nonempty"}, 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    pl = exp_q.pop_front();
                    chk({ctx, " stream_order"}, 128'(bus.iss_payload[k*PAYLOAD_W +: PAYLOAD_W]), 128'(pl));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.flush        = 1'b0;
        bus.issue_stall  = 1'b0;
        bus.wr_valid     = '0;
        bus.wr_src1_rdy  = '0;
        bus.wr_src2_rdy  = '0;
        bus.wr_src1_tag  = '0;
        bus.wr_src2_tag  = '0;
        bus.wr_src1_data = '0;
        bus.wr_src2_data = '0;
        bus.wr_payload   = '0;
        bus.wake_valid   = '0;
        bus.wake_tag     = '0;
        bus.wake_data    = '0;
    endtask

    task automatic drive_wr(input int p, input logic r1, input logic [TAG_W-1:0] t1,
                            input logic [DATA_W-1:0] d1, input logic r2,
                            input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2,
                            input logic [PAYLOAD_W-1:0] pl);
        bus.wr_valid[p]                         = 1'b1;
        bus.wr_src1_rdy[p]                      = r1;
        bus.wr_src2_rdy[p]                      = r2;
        bus.wr_src1_tag[p*TAG_W +: TAG_W]       = t1;
        bus.wr_src2_tag[p*TAG_W +: TAG_W]       = t2;
        bus.wr_src1_data[p*DATA_W +: DATA_W]    = d1;
        bus.wr_src2_data[p*DATA_W +: DATA_W]    = d2;
        bus.wr_payload[p*PAYLOAD_W +: PAYLOAD_W] = pl;
    endtask

    task automatic drive_wake(input int w, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        bus.wake_valid[w]                 = 1'b1;
        bus.wake_tag[w*TAG_W +: TAG_W]    = t;
        bus.wake_data[w*DATA_W +: DATA_W] = d;
    endtask

    // Status check before the edge, model update, then output check just after the edge.
    task automatic cycle(input string ctx);
        chk({ctx, " count"}, 128'(bus.count), 128'(mq.size()));
        chk({ctx, " full"}, 128'(bus.full), 128'(mq.size() > DEPTH - WRITE_NUM));
        model_step();
        @(posedge clk);
        #1;
        check_out(ctx);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        resetn = 1'b0;
        drive_idle();
        model_reset();
        #23;
        chk("reset iss_valid", 128'(bus.iss_valid), 128'(0));
        chk("reset count", 128'(bus.count), 128'(0));
        chk("reset full", 128'(bus.full), 128'(0));
        chk("reset payload", 128'(bus.iss_payload), 128'(0));
        @(negedge clk);
        resetn = 1'b1;

        // Two ready ops issue together, oldest on port 0.
        drive_idle();
        drive_wr(0, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h12, 64'hA);
        drive_wr(1, 1'b1, 6'd0, 32'h21, 1'b1, 6'd0, 32'h22, 64'hB);
        cycle("t1_write");
        drive_idle();
        chk("t1 count2", 128'(bus.count), 128'(2));
        cycle("t1_issue");
        chk("t1 iss_valid", 128'(bus.iss_valid), 128'(2'b11));
        chk("t1 pl0", 128'(bus.iss_payload[63:0]), 128'(64'hA));
        chk("t1 pl1", 128'(bus.iss_payload[127:64]), 128'(64'hB));
        chk("t1 count0", 128'(bus.count), 128'(0));

        // Same-cycle wake of a fresh write; lowest matching port wins; tag 0 never wakes.
        drive_idle();
        drive_wr(0, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h55, 64'h20);
        drive_wr(1, 1'b0, 6'd0, 32'h0, 1'b1, 6'd0, 32'h66, 64'h21);
        drive_wake(0, 6'd0, 32'hBAD);
        drive_wake(2, 6'd5, 32'h1234);
        drive_wake(3, 6'd5, 32'hDEAD);
        cycle("t2_write");
        drive_idle();
        cycle("t2_issue");
        chk("t2 iss_valid", 128'(bus.iss_valid), 128'(2'b01));
        chk("t2 src1", 128'(bus.iss_src1_data[31:0]), 128'(32'h1234));
        chk("t2 tag0 stays", 128'(bus.count), 128'(1));
        bus.flush = 1'b1;
        cycle("t2_flush");

        // Fill to full, then writes are refused without disturbing contents.
        for (int c = 0; c < 4; c++) begin
            drive_idle();
            drive_wr(0, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'(c), 64'(32'h30 + 2 * c));
            drive_wr(1, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'(c), 64'(32'h31 + 2 * c));
            cycle("t3_fill");
        end
        drive_idle();
        chk("t3 count8", 128'(bus.count), 128'(8));
        chk("t3 full", 128'(bus.full), 128'(1));
        drive_wr(0, 1'b1, 6'd0, 32'hEE, 1'b1, 6'd0, 32'hEE, 64'hEE);
        drive_wr(1, 1'b1, 6'd0, 32'hEF, 1'b1, 6'd0, 32'hEF, 64'hEF);
        cycle("t3_refused");
        drive_idle();
        chk("t3 count stays", 128'(bus.count), 128'(8));
        drive_wake(1, 6'd9, 32'h9999);
        cycle("t3_wake");
        drive_idle();
        for (int c = 0; c < 5; c++) cycle("t3_drain");

        // Only entries 1 and 3 ready: they issue, 0 and 2 keep their order.
        drive_idle();
        bus.issue_stall = 1'b1;
        drive_wr(0, 1'b0, 6'd10, 32'h0, 1'b1, 6'd0, 32'h40, 64'h40);
        drive_wr(1, 1'b1, 6'd0, 32'h41, 1'b1, 6'd0, 32'h41, 64'h41);
        cycle("t4_w01");
        drive_idle();
        bus.issue_stall = 1'b1;
        drive_wr(0, 1'b0, 6'd11, 32'h0, 1'b1, 6'd0, 32'h42, 64'h42);
        drive_wr(1, 1'b1, 6'd0, 32'h43, 1'b1, 6'd0, 32'h43, 64'h43);
        cycle("t4_w23");
        drive_idle();
        cycle("t4_issue");
        chk("t4 port0", 128'(bus.iss_payload[63:0]), 128'(64'h41));
        chk("t4 port1", 128'(bus.iss_payload[127:64]), 128'(64'h43));
        drive_wake(0, 6'd11, 32'hB11);
        drive_wake(1, 6'd10, 32'hA10);
        cycle("t4_wake");
        drive_idle();
        cycle("t4_issue2");
        chk("t4 order0", 128'(bus.iss_payload[63:0]), 128'(64'h40));
        chk("t4 order1", 128'(bus.iss_payload[127:64]), 128'(64'h42));

        // Stall holds outputs and contents for 4 cycles, then the two oldest go.
        drive_idle();
        bus.issue_stall = 1'b1;
        drive_wr(0, 1'b1, 6'd0, 32'h50, 1'b1, 6'd0, 32'h50, 64'h50);
        drive_wr(1, 1'b1, 6'd0, 32'h51, 1'b1, 6'd0, 32'h51, 64'h51);
        cycle("t5_stall");
        drive_idle();
        bus.issue_stall = 1'b1;
        drive_wr(0, 1'b1, 6'd0, 32'h52, 1'b1, 6'd0, 32'h52, 64'h52);
        cycle("t5_stall");
        drive_idle();
        bus.issue_stall = 1'b1;
        cycle("t5_stall");
        cycle("t5_stall");
        chk("t5 count3", 128'(bus.count), 128'(3));
        chk("t5 held", 128'(bus.iss_payload[63:0]), 128'(64'h40));
        drive_idle();
        cycle("t5_release");
        chk("t5 rel0", 128'(bus.iss_payload[63:0]), 128'(64'h50));
        chk("t5 rel1", 128'(bus.iss_payload[127:64]), 128'(64'h51));
        cycle("t5_last");

        // Flush under stall with concurrent writes clears queue and iss_valid.
        drive_idle();
        drive_wr(0, 1'b1, 6'd0, 32'h60, 1'b1, 6'd0, 32'h60, 64'h60);
        drive_wr(1, 1'b1, 6'd0, 32'h61, 1'b1, 6'd0, 32'h61, 64'h61);
        cycle("t6_a");
        drive_idle();
        drive_wr(0, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h62, 64'h62);
        drive_wr(1, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h63, 64'h63);
        cycle("t6_b");
        drive_idle();
        drive_wr(0, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h64, 64'h64);
        drive_wr(1, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h65, 64'h65);
        cycle("t6_c");
        drive_idle();
        bus.issue_stall = 1'b1;
        drive_wr(0, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h66, 64'h66);
        cycle("t6_d");
        chk("t6 count5", 128'(bus.count), 128'(5));
        drive_idle();
        bus.flush       = 1'b1;
        bus.issue_stall = 1'b1;
        drive_wr(0, 1'b1, 6'd0, 32'h67, 1'b1, 6'd0, 32'h67, 64'h67);
        drive_wr(1, 1'b1, 6'd0, 32'h68, 1'b1, 6'd0, 32'h68, 64'h68);
        cycle("t6_flush");
        chk("t6 count0", 128'(bus.count), 128'(0));
        chk("t6 iss_valid0", 128'(bus.iss_valid), 128'(0));

        // Asynchronous reset while ops are being issued.
        drive_idle();
        drive_wr(0, 1'b1, 6'd0, 32'h70, 1'b1, 6'd0, 32'h70, 64'h70);
        drive_wr(1, 1'b1, 6'd0, 32'h71, 1'b1, 6'd0, 32'h71, 64'h71);
        cycle("t7_write");
        drive_idle();
        drive_wr(0, 1'b0, 6'd13, 32'h0, 1'b1, 6'd0, 32'h72, 64'h72);
        cycle("t7_issue");
        #2;
        resetn = 1'b0;
        #1;
        chk("t7 async iss_valid", 128'(bus.iss_valid), 128'(0));
        chk("t7 async count", 128'(bus.count), 128'(0));
        model_reset();
        drive_idle();
        @(negedge clk);
        resetn = 1'b1;
        cycle("t7_after");

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            bus.issue_stall = ($urandom_range(0, 4) == 0);
            bus.flush       = ($urandom_range(0, 40) == 0);
            for (int p = 0; p < WRITE_NUM; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    drive_wr(p, 1'($urandom_range(0, 1)), TAG_W'($urandom_range(1, 7)), DATA_W'($urandom),
                             1'($urandom_range(0, 1)), TAG_W'($urandom_range(1, 7)), DATA_W'($urandom),
                             {$urandom, $urandom});
                end
            end
            for (int w = 0; w < WAKE_NUM; w++) begin
                if ($urandom_range(0, 2) == 0) begin
                    drive_wake(w, TAG_W'($urandom_range(1, 7)), DATA_W'($urandom));
                end
            end
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
